trans_scan_scheduler: RTL

- Sequences the 49-element ultrasonic transducer array through a programmable scan.
- Drives one transducer at a time with 40 kHz square-wave bursts of programmable length, separated by programmable silent gaps.
- Generates the carrier internally and switches transducers only on carrier-period boundaries, so no output ever carries a truncated pulse.
- Sits between the host/config logic (start/stop, scan range) and the transducer driver pins. It replaces the fixed 1 s round-robin scan with a host-controlled scheduler.

---
 rtl/trans_scan_scheduler_pkg.sv | 21 ++
 rtl/trans_scan_scheduler_if.sv | 31 +++
 rtl/trans_scan_scheduler_carrier_gen.sv | 32 +++
 rtl/trans_scan_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/trans_scan_scheduler_pkg.sv
// Shared definitions for the transducer scan scheduler.
// Holds the FSM state encoding, the carrier/array constants shared with the
// existing transducer logic, and the start-config validity check.
package trans_scan_scheduler_pkg;

  localparam int PERIOD_CNT = 1250;  // 50 MHz / 40 kHz
  localparam int DUTY_CNT   = 625;   // 50 % high
  localparam int N_TRANS    = 49;
  localparam int LEN_W      = 16;
  localparam int IDX_W      = 6;

  typedef enum logic [1:0] {IDLE, ARM, BURST, GAP} state_e;

  // A scan range is usable when it is non-empty and inside the array.
  function automatic logic cfg_ok(input logic [IDX_W-1:0] first,
                                  input logic [IDX_W-1:0] last,
                                  input int               n);
    return (first <= last) && (int'(last) < n);
  endfunction

endpackage

// File: rtl/trans_scan_scheduler_if.sv
// Host <-> scheduler bundle.
//   master: host/config side (drives start/stop/config, reads status + trans)
//   slave : scheduler side
interface trans_scan_scheduler_if #(
  parameter int N_TRANS = trans_scan_scheduler_pkg::N_TRANS,
  parameter int LEN_W   = trans_scan_scheduler_pkg::LEN_W
);
  logic                                        start;
  logic                                        stop;
  logic                                        loop_en;
  logic [trans_scan_scheduler_pkg::IDX_W-1:0]  first_idx;
  logic [trans_scan_scheduler_pkg::IDX_W-1:0]  last_idx;
  logic [LEN_W-1:0]                            burst_len;
  logic [LEN_W-1:0]                            gap_len;
  logic                                        busy;
  logic                                        done;
  logic                                        cfg_err;
  logic [trans_scan_scheduler_pkg::IDX_W-1:0]  cur_idx;
  logic                                        period_tick;
  logic [N_TRANS-1:0]                          trans;

  modport master (
    output start, stop, loop_en, first_idx, last_idx, burst_len, gap_len,
    input  busy, done, cfg_err, cur_idx, period_tick, trans
  );

  modport slave (
    input  start, stop, loop_en, first_idx, last_idx, burst_len, gap_len,
    output busy, done, cfg_err, cur_idx, period_tick, trans
  );
endinterface

// File: rtl/trans_scan_scheduler_carrier_gen.sv
// Free-running carrier period counter.
//   CLK, RST    : clock, synchronous active-high reset (cnt -> 0)
//   pbound      : current cycle is the last of the carrier period
//   pbound_nxt  : next cycle will be the last of the period
//   carrier_nxt : carrier level (cnt < DUTY_CNT) for the next cycle
// The *_nxt outputs let the parent register its outputs without a cycle lag.
module trans_scan_scheduler_carrier_gen #(
  parameter int PERIOD_CNT = trans_scan_scheduler_pkg::PERIOD_CNT,
  parameter int DUTY_CNT   = trans_scan_scheduler_pkg::DUTY_CNT
) (
  input  logic CLK,
  input  logic RST,
  output logic pbound,
  output logic pbound_nxt,
  output logic carrier_nxt
);
  localparam int CW = $clog2(PERIOD_CNT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = (cnt_q == CW'(PERIOD_CNT - 1)) ? '0 : cnt_q + 1'b1;
    pbound      = (cnt_q == CW'(PERIOD_CNT - 1));
    pbound_nxt  = (cnt_d == CW'(PERIOD_CNT - 1));
    carrier_nxt = (cnt_d <  CW'(DUTY_CNT));
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/trans_scan_scheduler.sv
// Host-controlled scan scheduler for the ultrasonic transducer array.
// Drives one transducer at a time with bursts of whole carrier periods,
// separated by silent gaps; all transitions happen on period boundaries.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of trans_scan_scheduler_if (start/stop/config in,
//              busy/done/cfg_err/cur_idx/period_tick/trans out, all registered)
module trans_scan_scheduler
  import trans_scan_scheduler_pkg::*;
#(
  parameter int PERIOD_CNT = trans_scan_scheduler_pkg::PERIOD_CNT,
  parameter int DUTY_CNT   = trans_scan_scheduler_pkg::DUTY_CNT,
  parameter int N_TRANS    = trans_scan_scheduler_pkg::N_TRANS,
  parameter int LEN_W      = trans_scan_scheduler_pkg::LEN_W
) (
  input logic                   CLK,
  input logic                   RST,
  trans_scan_scheduler_if.slave bus
);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, first_q, first_d, last_q, last_d;
  logic [LEN_W-1:0]   per_q, per_d, burst_m1_q, burst_m1_d, gap_q, gap_d;
  logic               loop_q, loop_d, stop_pend_q, stop_pend_d;
  logic               busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic               tick_q;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [N_TRANS-1:0] trans_q, trans_d;
  logic               pbound, pbound_nxt, carrier_nxt;
  logic               adv, stop_now, drive;

  trans_scan_scheduler_carrier_gen #(
    .PERIOD_CNT (PERIOD_CNT),
    .DUTY_CNT   (DUTY_CNT)
  ) u_carrier (
    .CLK         (CLK),
    .RST         (RST),
    .pbound      (pbound),
    .pbound_nxt  (pbound_nxt),
    .carrier_nxt (carrier_nxt)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    per_d       = per_q;
    first_d     = first_q;
    last_d      = last_q;
    burst_m1_d  = burst_m1_q;
    gap_d       = gap_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    adv         = 1'b0;
    // A stop landing on the boundary cycle itself takes effect there.
    stop_now    = (state_q != IDLE) && (stop_pend_q || bus.stop);

    unique case (state_q)
      IDLE: if (bus.start) begin
        if (cfg_ok(bus.first_idx, bus.last_idx, N_TRANS)) begin
          first_d    = bus.first_idx;
          last_d     = bus.last_idx;
          // burst_len 0 behaves as 1; storing len-1 avoids a LEN_W+1 compare.
          burst_m1_d = (bus.burst_len == '0) ? '0 : bus.burst_len - 1'b1;
          gap_d      = bus.gap_len;
          loop_d     = bus.loop_en;
          state_d    = ARM;
        end else begin
          cfg_err_d  = 1'b1;
        end
      end
      ARM: if (pbound) begin
        state_d = BURST;
        idx_d   = first_q;
        per_d   = '0;
      end
      BURST: if (pbound) begin
        if (per_q == burst_m1_q) begin
          per_d = '0;
          if (gap_q != '0) state_d = GAP;
          else             adv     = 1'b1;
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      GAP: if (pbound) begin
        if (per_q == gap_q - 1'b1) begin
          per_d = '0;
          adv   = 1'b1;
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (idx_q < last_q) begin
        idx_d   = idx_q + 1'b1;
        state_d = BURST;
      end else if (loop_q) begin
        idx_d   = first_q;
        state_d = BURST;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (state_q != IDLE && bus.stop) stop_pend_d = 1'b1;
    if (stop_now && pbound) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    if (state_d == IDLE) stop_pend_d = 1'b0;

    // Outputs are decoded from next state / next cnt so they line up with
    // the carrier edges once registered.
    busy_d    = (state_d != IDLE);
    cur_idx_d = (state_d == BURST || state_d == GAP) ? idx_d : '0;
    drive     = (state_d == BURST) && carrier_nxt;
    for (int i = 0; i < N_TRANS; i++) trans_d[i] = drive && (idx_d == IDX_W'(i));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      per_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      burst_m1_q  <= '0;
      gap_q       <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      tick_q      <= 1'b0;
      cur_idx_q   <= '0;
      trans_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      per_q       <= per_d;
      first_q     <= first_d;
      last_q      <= last_d;
      burst_m1_q  <= burst_m1_d;
      gap_q       <= gap_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      tick_q      <= pbound_nxt;
      cur_idx_q   <= cur_idx_d;
      trans_q     <= trans_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.cur_idx     = cur_idx_q;
  assign bus.period_tick = tick_q;
  assign bus.trans       = trans_q;
endmodule
